// File: rtl/falafel_input_parser.sv
// Host request parser for the falafel allocator: decodes header/payload word pairs
// into config register writes, aligned allocation requests and free requests.
package falafel_pkg;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OP_W   = 4;

  localparam int unsigned BLOCK_ALIGNMENT  = 8;
  localparam int unsigned MIN_PAYLOAD_SIZE = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NULL_PTR = '0;

  localparam logic [OP_W-1:0] REQ_ACCESS_REGISTER = 4'd0;
  localparam logic [OP_W-1:0] REQ_ALLOC_MEM       = 4'd1;
  localparam logic [OP_W-1:0] REQ_FREE_MEM        = 4'd2;

  localparam logic [ADDR_W-1:0] ADDR_FREE_LIST_PTR = 16'h0010;
  localparam logic [ADDR_W-1:0] ADDR_LOCK_PTR      = 16'h0018;
  localparam logic [ADDR_W-1:0] ADDR_LOCK_ID       = 16'h0020;

  typedef struct packed {
    logic [ID_W-1:0] id;
    word_t           size;
  } alloc_entry_t;

  typedef struct packed {
    word_t free_list_ptr;
    word_t lock_ptr;
    word_t lock_id;
  } config_regs_t;

  // Clamp to the minimum size, then round up to the alignment granule (power of two).
  function automatic word_t align_size(input word_t size, input word_t alignment,
                                       input word_t min_size);
    word_t s;
    s = (size < min_size) ? min_size : size;
    return (s + alignment - WORD_W'(1)) & ~(alignment - WORD_W'(1));
  endfunction
endpackage

module falafel_input_parser
  import falafel_pkg::*;
#(
  parameter int unsigned ALIGNMENT = BLOCK_ALIGNMENT,
  parameter int unsigned MIN_SIZE  = MIN_PAYLOAD_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  word_t                in_data_i,
  output logic                 alloc_valid_o,
  input  logic                 alloc_ready_i,
  output alloc_entry_t         alloc_req_o,
  output logic                 free_valid_o,
  input  logic                 free_ready_i,
  output logic [ID_W-1:0]      free_id_o,
  output word_t                free_ptr_o,
  output config_regs_t         cfg_regs_o,
  output logic                 bad_req_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_ALLOC_OUT,
    ST_FREE_OUT
  } state_t;

  // Largest payload whose rounded size still fits in a word.
  localparam word_t ALLOC_LIMIT = word_t'(0) - word_t'(ALIGNMENT);

  state_t            r_state, w_state_nxt;
  logic [OP_W-1:0]   r_op, w_op_nxt;
  logic [ID_W-1:0]   r_id, w_id_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic              r_in_ready;
  logic              r_alloc_valid;
  logic              r_free_valid;
  logic              r_bad, w_bad_nxt;
  alloc_entry_t      r_alloc_req, w_alloc_req_nxt;
  logic [ID_W-1:0]   r_free_id, w_free_id_nxt;
  word_t             r_free_ptr, w_free_ptr_nxt;
  config_regs_t      r_cfg, w_cfg_nxt;

  logic              w_accept;
  logic [OP_W-1:0]   w_hdr_op;
  word_t             w_aligned;

  assign w_accept  = in_valid_i && r_in_ready;
  assign w_hdr_op  = in_data_i[3:0];
  assign w_aligned = align_size(in_data_i, word_t'(ALIGNMENT), word_t'(MIN_SIZE));

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_id          <= '0;
      r_addr        <= '0;
      r_in_ready    <= 1'b1;
      r_alloc_valid <= 1'b0;
      r_free_valid  <= 1'b0;
      r_bad         <= 1'b0;
      r_alloc_req   <= '0;
      r_free_id     <= '0;
      r_free_ptr    <= '0;
      r_cfg         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_op          <= w_op_nxt;
      r_id          <= w_id_nxt;
      r_addr        <= w_addr_nxt;
      r_in_ready    <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_PAYLOAD);
      r_alloc_valid <= (w_state_nxt == ST_ALLOC_OUT);
      r_free_valid  <= (w_state_nxt == ST_FREE_OUT);
      r_bad         <= w_bad_nxt;
      r_alloc_req   <= w_alloc_req_nxt;
      r_free_id     <= w_free_id_nxt;
      r_free_ptr    <= w_free_ptr_nxt;
      r_cfg         <= w_cfg_nxt;
    end
  end

  // Next-state decode and message handling.
  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_id_nxt        = r_id;
    w_addr_nxt      = r_addr;
    w_bad_nxt       = 1'b0;
    w_alloc_req_nxt = r_alloc_req;
    w_free_id_nxt   = r_free_id;
    w_free_ptr_nxt  = r_free_ptr;
    w_cfg_nxt       = r_cfg;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_hdr_op <= REQ_FREE_MEM) begin
            w_op_nxt    = w_hdr_op;
            w_id_nxt    = in_data_i[11:4];
            w_addr_nxt  = in_data_i[27:12];
            w_state_nxt = ST_PAYLOAD;
          end else begin
            w_bad_nxt = 1'b1;
          end
        end
      end

      ST_PAYLOAD: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
          case (r_op)
            REQ_ACCESS_REGISTER: begin
              case (r_addr)
                ADDR_FREE_LIST_PTR: w_cfg_nxt.free_list_ptr = in_data_i;
                ADDR_LOCK_PTR:      w_cfg_nxt.lock_ptr      = in_data_i;
                ADDR_LOCK_ID:       w_cfg_nxt.lock_id       = in_data_i;
                default:            w_bad_nxt               = 1'b1;
              endcase
            end
            REQ_ALLOC_MEM: begin
              if (in_data_i > ALLOC_LIMIT) begin
                w_bad_nxt = 1'b1;
              end else begin
                w_alloc_req_nxt.id   = r_id;
                w_alloc_req_nxt.size = w_aligned;
                w_state_nxt          = ST_ALLOC_OUT;
              end
            end
            REQ_FREE_MEM: begin
              if (in_data_i == NULL_PTR) begin
                w_bad_nxt = 1'b1;
              end else begin
                w_free_id_nxt  = r_id;
                w_free_ptr_nxt = in_data_i;
                w_state_nxt    = ST_FREE_OUT;
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end

      ST_ALLOC_OUT: if (alloc_ready_i) w_state_nxt = ST_IDLE;

      ST_FREE_OUT:  if (free_ready_i) w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign in_ready_o    = r_in_ready;
  assign alloc_valid_o = r_alloc_valid;
  assign alloc_req_o   = r_alloc_req;
  assign free_valid_o  = r_free_valid;
  assign free_id_o     = r_free_id;
  assign free_ptr_o    = r_free_ptr;
  assign cfg_regs_o    = r_cfg;
  assign bad_req_o     = r_bad;

endmodule

// File: tb/tb_falafel_input_parser.sv
// Scoreboard bench for falafel_input_parser: directed scenarios plus random message
// traffic, checked against an arithmetic model of the message rules.
module tb_falafel_input_parser;
  import falafel_pkg::*;

  localparam int unsigned A_GRAN  = 8;
  localparam int unsigned MIN_SZ  = 32;
  localparam int unsigned N_RAND  = 300;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  word_t        in_data_i = '0;
  logic         alloc_valid_o;
  logic         alloc_ready_i = 1'b0;
  alloc_entry_t alloc_req_o;
  logic         free_valid_o;
  logic         free_ready_i = 1'b0;
  logic [7:0]   free_id_o;
  word_t        free_ptr_o;
  config_regs_t cfg_regs_o;
  logic         bad_req_o;

  falafel_input_parser dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .alloc_valid_o(alloc_valid_o), .alloc_ready_i(alloc_ready_i), .alloc_req_o(alloc_req_o),
    .free_valid_o(free_valid_o), .free_ready_i(free_ready_i),
    .free_id_o(free_id_o), .free_ptr_o(free_ptr_o),
    .cfg_regs_o(cfg_regs_o), .bad_req_o(bad_req_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  config_regs_t exp_cfg = '0;
  logic [71:0]  alloc_q[$];
  logic [71:0]  free_q[$];
  int           bad_pending = 0;
  int           rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Core-side ready generation, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: begin alloc_ready_i = 1'b0; free_ready_i = 1'b0; end
      2: begin alloc_ready_i = 1'b1; free_ready_i = 1'b1; end
      default: begin
        alloc_ready_i = ($urandom_range(0, 3) != 0);
        free_ready_i  = ($urandom_range(0, 3) != 0);
      end
    endcase
  end

  // Monitor: compares DUT outputs against the scoreboard on every falling edge.
  always @(negedge clk) begin
    if (rst_ni) begin
      check("cfg_regs", cfg_regs_o, exp_cfg);
      check("in_ready", in_ready_o, !(alloc_valid_o || free_valid_o));
      if (alloc_valid_o) begin
        if (alloc_q.size() == 0) check("alloc_unexpected", 1'b1, 1'b0);
        else begin
          check("alloc_req", alloc_req_o, alloc_q[0]);
          if (alloc_ready_i) void'(alloc_q.pop_front());
        end
      end
      if (free_valid_o) begin
        if (free_q.size() == 0) check("free_unexpected", 1'b1, 1'b0);
        else begin
          check("free_req", {free_id_o, free_ptr_o}, free_q[0]);
          if (free_ready_i) void'(free_q.pop_front());
        end
      end
      if (bad_req_o) begin
        if (bad_pending == 0) check("bad_unexpected", 1'b1, 1'b0);
        else bad_pending--;
      end
    end
  end

  task automatic send_word(input word_t w);
    int n;
    in_valid_i = 1'b1;
    in_data_i  = w;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready_o && n < 200);
    if (!in_ready_o) begin
      check("in_ready_timeout", 1'b0, 1'b1);
      in_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic word_t mk_hdr(input logic [3:0] op, input logic [7:0] id,
                                   input logic [15:0] addr);
    logic [35:0] junk;
    junk = {4'($urandom), 32'($urandom)};
    return {junk, addr, id, op};
  endfunction

  // Expected effect of an accepted payload, derived from the message rules.
  task automatic model_payload(input logic [3:0] op, input logic [7:0] id,
                               input logic [15:0] addr, input word_t pl);
    logic [64:0] s, a;
    case (op)
      4'd0: begin
        if (addr == 16'h0010) exp_cfg.free_list_ptr = pl;
        else if (addr == 16'h0018) exp_cfg.lock_ptr = pl;
        else if (addr == 16'h0020) exp_cfg.lock_id = pl;
        else bad_pending++;
      end
      4'd1: begin
        s = (pl < 64'(MIN_SZ)) ? 65'(MIN_SZ) : {1'b0, pl};
        a = ((s + 65'(A_GRAN) - 65'd1) / 65'(A_GRAN)) * 65'(A_GRAN);
        if (a[64]) bad_pending++;
        else alloc_q.push_back({id, a[63:0]});
      end
      default: begin
        if (pl == 64'd0) bad_pending++;
        else free_q.push_back({id, pl});
      end
    endcase
  endtask

  task automatic send_msg(input logic [3:0] op, input logic [7:0] id,
                          input logic [15:0] addr, input word_t pl, input bit gap);
    send_word(mk_hdr(op, id, addr));
    if (op > 4'd2) begin
      bad_pending++;
      return;
    end
    if (gap) idle($urandom_range(1, 3));
    send_word(pl);
    model_payload(op, id, addr, pl);
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((alloc_q.size() != 0 || free_q.size() != 0 || bad_pending != 0) && n < 300);
    check("drain", {alloc_q.size() == 0, free_q.size() == 0, bad_pending == 0}, 3'b111);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    @(posedge clk);
    #1;
    exp_cfg = '0;
    alloc_q.delete();
    free_q.delete();
    bad_pending = 0;
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst_valids_bad", {alloc_valid_o, free_valid_o, bad_req_o}, 3'b000);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_alloc_req", alloc_req_o, 72'd0);
    check("rst_free", {free_id_o, free_ptr_o}, 72'd0);
    check("rst_cfg", cfg_regs_o, 192'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  op;
    logic [15:0] addr;
    word_t       pl;
    int          k;

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    rdy_mode = 2;

    // Register write to free_list_ptr only.
    send_msg(4'd0, 8'd0, 16'h0010, 64'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("reg_free_list_ptr", cfg_regs_o, {64'hDEAD_BEEF, 64'd0, 64'd0});
    @(posedge clk);
    #1;

    // Alloc held with ready low: valid stays up, stream stalls, request stable.
    rdy_mode = 1;
    send_msg(4'd1, 8'd5, 16'h0, 64'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_valid_ready", {alloc_valid_o, in_ready_o}, 2'b10);
      check("hold_req", alloc_req_o, {8'd5, 64'd32});
    end
    rdy_mode = 2;
    wait_drain();
    send_msg(4'd1, 8'd5, 16'h0, 64'd32, 1'b0);
    send_msg(4'd1, 8'd5, 16'h0, 64'd33, 1'b0);
    send_msg(4'd1, 8'd5, 16'h0, 64'd0, 1'b0);
    wait_drain();

    // Rounding overflow boundary.
    send_msg(4'd1, 8'd6, 16'h0, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);
    send_msg(4'd1, 8'd6, 16'h0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
    wait_drain();

    // Free requests, including the null pointer.
    send_msg(4'd2, 8'd7, 16'h0, 64'h1000, 1'b0);
    send_msg(4'd2, 8'd7, 16'h0, 64'h0, 1'b0);
    wait_drain();

    // Unknown opcode consumes one word; then lock_ptr write and a bad address.
    send_msg(4'd9, 8'd1, 16'h0, 64'h0, 1'b0);
    send_msg(4'd0, 8'd2, 16'h0018, 64'h1234_5678_9ABC_DEF0, 1'b0);
    send_msg(4'd0, 8'd3, 16'h0028, 64'h5555, 1'b1);
    wait_drain();

    // Reset during ALLOC_OUT, then between header and payload.
    rdy_mode = 1;
    send_msg(4'd1, 8'd8, 16'h0, 64'd100, 1'b0);
    @(negedge clk);
    check("pre_rst_alloc_valid", alloc_valid_o, 1'b1);
    @(posedge clk);
    #1;
    do_reset();
    send_word(mk_hdr(4'd1, 8'd9, 16'h0));
    do_reset();
    rdy_mode = 2;
    send_msg(4'd1, 8'd10, 16'h0, 64'd40, 1'b0);
    send_msg(4'd0, 8'd11, 16'h0020, 64'hABCD, 1'b0);
    wait_drain();

    // Random traffic with random core back-pressure and input gaps.
    rdy_mode = 0;
    for (int i = 0; i < N_RAND; i++) begin
      k = $urandom_range(0, 19);
      addr = 16'($urandom);
      pl = {32'($urandom), 32'($urandom)};
      if (k < 6) begin
        op = 4'd0;
        case ($urandom_range(0, 3))
          0: addr = 16'h0010;
          1: addr = 16'h0018;
          2: addr = 16'h0020;
          default: ;
        endcase
      end else if (k < 13) begin
        op = 4'd1;
        case ($urandom_range(0, 2))
          0: pl = 64'($urandom_range(0, 80));
          1: pl = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 15));
          default: ;
        endcase
      end else if (k < 18) begin
        op = 4'd2;
        if ($urandom_range(0, 7) == 0) pl = 64'd0;
      end else begin
        op = 4'($urandom_range(3, 15));
      end
      send_msg(op, 8'($urandom), addr, pl, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 2;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
